// File: rtl/fsm_frame_ctrl_pkg.sv
// State encoding and width helper shared by the frame sequencer, its bus interface and the bench.
package fsm_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLR    = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_REPORT = 3'd4
  } state_e;

  // Hit counter width: a frame of w bits can produce at most w hits.
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/fsm_frame_ctrl_if.sv
// Frame-in / hit-count-out valid/ready bundle; master offers frames and takes results,
// slave is the sequencer.
interface fsm_frame_ctrl_if #(
  parameter int W = 8
) ();
  localparam int CNT_W = fsm_ctrl_pkg::cnt_w(W);

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] res_hits;

  modport master (
    output in_valid, in_data, res_ready,
    input  in_ready, res_valid, res_hits
  );

  modport slave (
    input  in_valid, in_data, res_ready,
    output in_ready, res_valid, res_hits
  );
endinterface

// File: rtl/fsm_frame_ctrl_det_en_dly.sv
// Delays det_en by DET_LAT clocks so hit sampling lines up with the detector's output latency;
// DET_LAT=0 is a wire.
module det_en_dly #(
  parameter int DET_LAT = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic en_i,
  output logic en_d_o
);

  if (DET_LAT == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rstn;
    assign en_d_o = en_i;
  end else begin : g_dly
    logic [DET_LAT-1:0] pipe_q;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        pipe_q <= '0;
      end else begin
        pipe_q[0] <= en_i;
        for (int i = 1; i < DET_LAT; i++) begin
          pipe_q[i] <= pipe_q[i-1];
        end
      end
    end

    assign en_d_o = pipe_q[DET_LAT-1];
  end

endmodule

// File: rtl/fsm_frame_ctrl.sv
// Streams W-bit frames MSB-first into a serial detector and returns the per-frame hit count.
// Result valid 1+CLEAR_EACH+W+DET_LAT edges after accept; accepts only in IDLE, holds result until taken.
module fsm_frame_ctrl
  import fsm_ctrl_pkg::*;
#(
  parameter int W          = 8,
  parameter int DET_LAT    = 1,
  parameter int CLEAR_EACH = 1
) (
  input  logic            clk,
  input  logic            rstn,
  fsm_frame_ctrl_if.slave bus,
  output logic            det_x,
  output logic            det_en,
  output logic            det_clr,
  input  logic            det_out
);

  localparam int CNT_W = cnt_w(W);
  localparam int IDX_W = $clog2(W);
  localparam int LAT_W = 3;

  state_e           state_q;
  logic [W-1:0]     shreg_q;
  logic [IDX_W-1:0] bit_idx_q;
  logic [LAT_W-1:0] lat_q;
  logic [CNT_W-1:0] hits_q;
  logic [CNT_W-1:0] hits_d;
  logic             in_ready_q;
  logic             res_valid_q;
  logic             det_x_q;
  logic             det_en_q;
  logic             det_clr_q;
  logic             en_d;

  det_en_dly #(
    .DET_LAT (DET_LAT)
  ) u_det_en_dly (
    .clk    (clk),
    .rstn   (rstn),
    .en_i   (det_en_q),
    .en_d_o (en_d)
  );

  // en_d is high for exactly the W cycles whose det_out belongs to this frame.
  assign hits_d = (en_d && det_out) ? hits_q + CNT_W'(1) : hits_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      bit_idx_q   <= '0;
      lat_q       <= '0;
      hits_q      <= '0;
      in_ready_q  <= 1'b1;
      res_valid_q <= 1'b0;
      det_x_q     <= 1'b0;
      det_en_q    <= 1'b0;
      det_clr_q   <= 1'b0;
    end else begin
      hits_q <= hits_d;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            in_ready_q <= 1'b0;
            hits_q     <= '0;
            bit_idx_q  <= '0;
            if (CLEAR_EACH != 0) begin
              state_q   <= ST_CLR;
              shreg_q   <= bus.in_data;
              det_clr_q <= 1'b1;
            end else begin
              // No clear cycle: first bit goes straight out, shreg keeps the rest.
              state_q  <= ST_SHIFT;
              shreg_q  <= {bus.in_data[W-2:0], 1'b0};
              det_x_q  <= bus.in_data[W-1];
              det_en_q <= 1'b1;
            end
          end
        end
        ST_CLR: begin
          state_q   <= ST_SHIFT;
          det_clr_q <= 1'b0;
          det_en_q  <= 1'b1;
          det_x_q   <= shreg_q[W-1];
          shreg_q   <= {shreg_q[W-2:0], 1'b0};
        end
        ST_SHIFT: begin
          if (bit_idx_q == IDX_W'(W - 1)) begin
            det_en_q <= 1'b0;
            det_x_q  <= 1'b0;
            if (DET_LAT != 0) begin
              state_q <= ST_FLUSH;
              lat_q   <= '0;
            end else begin
              state_q     <= ST_REPORT;
              res_valid_q <= 1'b1;
            end
          end else begin
            bit_idx_q <= bit_idx_q + IDX_W'(1);
            det_x_q   <= shreg_q[W-1];
            shreg_q   <= {shreg_q[W-2:0], 1'b0};
          end
        end
        ST_FLUSH: begin
          if (lat_q == LAT_W'(DET_LAT - 1)) begin
            state_q     <= ST_REPORT;
            res_valid_q <= 1'b1;
          end else begin
            lat_q <= lat_q + LAT_W'(1);
          end
        end
        ST_REPORT: begin
          if (bus.res_ready) begin
            state_q     <= ST_IDLE;
            res_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign det_x         = det_x_q;
  assign det_en        = det_en_q;
  assign det_clr       = det_clr_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_hits  = hits_q;

endmodule
